// File: rtl/rr_sel_arbiter_4.sv
// Four-way round-robin arbiter that drives a 4x1 mux select.
// One grant at a time, bounded hold time, one dead cycle between grants.
module rr_sel_arbiter_4 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid
);

  localparam logic [7:0] MH = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_d;
  logic [3:0] gnt_d;
  logic       valid_d;
  logic [7:0] hold_q, hold_d;

  logic [1:0] win, idx;
  logic       found;
  logic       rel;

  // Search starts just after the last granted index and wraps.
  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign rel = done | ~req[sel] | (hold_q == MH);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel;
    gnt_d   = gnt;
    valid_d = valid;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          valid_d = 1'b1;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          ptr_d   = sel;
          gnt_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'b11;
      sel     <= 2'b00;
      gnt     <= 4'b0000;
      valid   <= 1'b0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      valid   <= valid_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter_4.sv
// Bench for rr_sel_arbiter_4: two instances (hold 15 and hold 1)
// compared every cycle against a behavioural model.
module tb_rr_sel_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [3:0] req;
  logic [1:0] sel_a, sel_b;
  logic [3:0] gnt_a, gnt_b;
  logic       valid_a, valid_b;

  always #5 clk = ~clk;

  rr_sel_arbiter_4 #(.MAX_HOLD(15)) dut_a (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel_a), .gnt(gnt_a), .valid(valid_a)
  );

  rr_sel_arbiter_4 #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel_b), .gnt(gnt_b), .valid(valid_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  int m_busy[2];
  int m_sel[2];
  int m_ptr[2];
  int m_hold[2];
  int m_mh[2] = '{15, 1};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: rotating priority search and release rules in plain ints.
  task automatic step_model(input int i);
    int idx;
    if (rst) begin
      m_busy[i] = 0;
      m_sel[i]  = 0;
      m_ptr[i]  = 3;
      m_hold[i] = 0;
    end else if (m_busy[i] == 0) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_ptr[i] + k) % 4;
        if (m_busy[i] == 0 && req[idx]) begin
          m_busy[i] = 1;
          m_sel[i]  = idx;
          m_hold[i] = 1;
        end
      end
    end else if (done || !req[m_sel[i]] || m_hold[i] == m_mh[i]) begin
      m_busy[i] = 0;
      m_ptr[i]  = m_sel[i];
      m_hold[i] = 0;
    end else begin
      m_hold[i]++;
    end
  endtask

  function automatic int exp_gnt(input int i);
    return m_busy[i] ? (1 << m_sel[i]) : 0;
  endfunction

  task automatic compare();
    chk("sel_a", 32'(sel_a), 32'(m_sel[0]));
    chk("gnt_a", 32'(gnt_a), 32'(exp_gnt(0)));
    chk("valid_a", 32'(valid_a), 32'(m_busy[0]));
    chk("sel_b", 32'(sel_b), 32'(m_sel[1]));
    chk("gnt_b", 32'(gnt_b), 32'(exp_gnt(1)));
    chk("valid_b", 32'(valid_b), 32'(m_busy[1]));
    chk("gntsel_a", 32'(gnt_a[sel_a]), 32'(valid_a));
    chk("onehot_b", 32'($countones(gnt_b) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    step_model(0);
    step_model(1);
    #1;
    compare();
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    chk("rst_sel", 32'(sel_a), 32'd0);
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);

    // All request: index 0 first, held full 15 cycles, then index 1.
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk("first_sel", 32'(sel_a), 32'd0);
    chk("first_gnt", 32'(gnt_a), 32'd1);
    for (int c = 0; c < 14; c++) tick();
    chk("hold15_valid", 32'(valid_a), 32'd1);
    tick();
    chk("dead_valid", 32'(valid_a), 32'd0);
    tick();
    chk("next_sel", 32'(sel_a), 32'd1);
    chk("next_gnt", 32'(gnt_a), 32'd2);

    // Reset mid-grant on index 3 then regrant to 3.
    req = 4'b1000;
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_gnt", 32'(gnt_a), 32'd0);
    rst = 1'b0;
    tick();
    chk("postrst_sel", 32'(sel_a), 32'd3);

    // Done pulse on the cycle after each grant: 1010 alternates 1,3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      done = 1'b0;
      tick();
      chk("alt_sel", 32'(sel_a), (g % 2 == 0) ? 32'd1 : 32'd3);
      done = 1'b1;
      tick();
      chk("alt_dead", 32'(valid_a), 32'd0);
    end
    done = 1'b0;

    // Random traffic with occasional done and reset.
    for (int c = 0; c < 600; c++) begin
      req  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0)
        req = req | (4'b0001 << sel_a);
      done = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter_4.md
RR_SEL_ARBITER_4 -- requirements
Module: rr_sel_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum cycles one requester may hold a grant (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: req  input  4  request lines; bit i = requester i (i maps to mux input a,b,c,d for i=0..3).
REQ-005 Port: done  input  1  current owner finished; releases grant.
REQ-006 Port: sel  output  2  registered select code driving the 4x1 multiplexer select.
REQ-007 Port: gnt  output  4  registered one-hot grant; bit sel set while valid.
REQ-008 Port: valid  output  1  registered; high while a grant is active (mux output meaningful).

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE, GRANT.
REQ-010 The block SHALL keep a 2-bit priority pointer ptr holding the last granted index.
REQ-011 In IDLE with req != 0, the winner SHALL be the first set bit of req searched in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-012 On the edge following the IDLE cycle with req != 0: state = GRANT, sel = winner, gnt = one-hot(winner), valid = 1, hold_cnt = 1 (latency 1 cycle).
REQ-013 In IDLE with req == 0: state, sel, ptr unchanged; gnt = 0000; valid = 0.
REQ-014 In GRANT, release SHALL occur when any of: done = 1; req[sel] = 0; hold_cnt == MAX_HOLD.
REQ-015 In GRANT without release: sel, gnt, valid held; hold_cnt increments by 1 (8-bit, never exceeds MAX_HOLD).
REQ-016 On release edge: state = IDLE, ptr = sel, gnt = 0000, valid = 0, hold_cnt = 0; sel SHALL keep its last value.
REQ-017 Exactly one dead cycle (valid = 0) SHALL separate any two consecutive grants, including regrant to the same requester.
REQ-018 Simultaneous release conditions (e.g. done with req[sel] drop, or done at timeout) SHALL produce a single release, identical to REQ-016.
REQ-019 Requests changing on non-owner bits during GRANT SHALL not affect sel, gnt or valid.
REQ-020 gnt SHALL be 0000 or one-hot at all times, and gnt[sel] = valid.
REQ-021 With MAX_HOLD = 1 each grant SHALL last exactly one cycle.

Reset
REQ-022 When rst = 1 at an edge: state = IDLE, sel = 00, gnt = 0000, valid = 0, hold_cnt = 0, ptr = 11 (first search starts at index 0).
REQ-023 rst SHALL override all other inputs, including mid-GRANT; first grant after reset deasserts follows REQ-012 with ptr = 11.

Verification
REQ-024 Reset then req = 1111, done = 0, MAX_HOLD = 15 -> valid rises 1 cycle later, sel = 00, gnt = 0001, held 15 cycles, 1 dead cycle, then sel = 01, gnt = 0010.
REQ-025 req = 1010 constant, done pulsed 1 cycle after each grant -> grant sequence sel = 01, 11, 01, 11 with one dead cycle between each.
REQ-026 Grant on sel = 10, drop req[2] while req = 0001 -> next edge valid = 0, ptr = 10; following grant sel = 00, gnt = 0001.
REQ-027 Grant active on sel = 01, done = 1 and req[1] = 0 same cycle -> single release, valid = 0 for exactly one cycle, no double pointer advance.
REQ-028 rst asserted at hold_cnt = 5 of grant on sel = 11 -> next edge sel = 00, gnt = 0000, valid = 0; after rst low with req = 1000 -> sel = 11 one cycle later.
REQ-029 MAX_HOLD = 1, req = 0110 constant -> alternating sel = 01, 10 with valid pattern 1,0,1,0.
